// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative instruction cache with multi-word lines and a registered refill FSM.
// Optional hit/miss statistics ports are enabled by defining ICACHE_STATS_EN.
module icache_nway #(
    parameter int CACHE_SIZE  = 1024,
    parameter int BLOCK_WORDS = 4,
    parameter int WAYS        = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_instr,
    output logic        cpu_valid,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
`ifdef ICACHE_STATS_EN
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`else
    input  logic [31:0] mem_rdata
`endif
);

    localparam int NUM_SETS    = CACHE_SIZE / (4 * BLOCK_WORDS * WAYS);
    localparam int INDEX_BITS  = $clog2(NUM_SETS);
    localparam int OFFSET_BITS = $clog2(BLOCK_WORDS);
    localparam int TAG_BITS    = 30 - INDEX_BITS - OFFSET_BITS;
    localparam int IDX_W       = (INDEX_BITS > 0) ? INDEX_BITS : 1;
    localparam int OFF_W       = (OFFSET_BITS > 0) ? OFFSET_BITS : 1;
    localparam int WAY_W       = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MISS_REQ = 2'd1,
        ST_FILL     = 2'd2
    } state_t;

    state_t              state_r;
    logic                stall_r;
    logic                mem_req_r;
    logic [31:0]         mem_addr_r;
    logic [31:0]         cpu_instr_r;
    logic                cpu_valid_r;
    logic                pend_flush_r;
    logic [OFF_W-1:0]    cnt_r;
    logic [TAG_BITS-1:0] miss_tag_r;
    logic [IDX_W-1:0]    miss_idx_r;
    logic [OFF_W-1:0]    miss_word_r;
    logic [WAY_W-1:0]    victim_r;

    logic [TAG_BITS-1:0] tag_r   [NUM_SETS][WAYS];
    logic [31:0]         data_r  [NUM_SETS][WAYS][BLOCK_WORDS];
    logic [WAYS-1:0]     valid_r [NUM_SETS];
    logic [WAY_W-1:0]    ptr_r   [NUM_SETS];

    logic [TAG_BITS-1:0] req_tag_s;
    logic [IDX_W-1:0]    req_idx_s;
    logic [OFF_W-1:0]    req_word_s;
    logic                hit_s;
    logic [WAY_W-1:0]    hit_way_s;
    logic [31:0]         rd_data_s;
    logic                accept_s;
    logic                beat_s;
    logic                last_s;

    assign req_tag_s  = TAG_BITS'(cpu_addr >> (32 - TAG_BITS));
    assign req_idx_s  = IDX_W'((cpu_addr >> (OFFSET_BITS + 2)) & 32'(NUM_SETS - 1));
    assign req_word_s = OFF_W'((cpu_addr >> 2) & 32'(BLOCK_WORDS - 1));
    assign rd_data_s  = data_r[req_idx_s][hit_way_s][req_word_s];
    assign accept_s   = (state_r == ST_IDLE) && cpu_req && !flush;
    assign beat_s     = (state_r == ST_FILL) && mem_rvalid;
    assign last_s     = beat_s && (cnt_r == OFF_W'(BLOCK_WORDS - 1));

    assign cpu_instr = cpu_instr_r;
    assign cpu_valid = cpu_valid_r;
    assign stall     = stall_r;
    assign mem_req   = mem_req_r;
    assign mem_addr  = mem_addr_r;

    // Tag compare across all ways of the addressed set.
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_r[req_idx_s][w] && (tag_r[req_idx_s][w] == req_tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = WAY_W'(w);
            end else begin
                hit_s     = hit_s;
                hit_way_s = hit_way_s;
            end
        end
    end

    // Refill FSM, valid bits, victim pointers and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            stall_r      <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= 32'd0;
            cpu_instr_r  <= 32'd0;
            cpu_valid_r  <= 1'b0;
            pend_flush_r <= 1'b0;
            cnt_r        <= '0;
            miss_tag_r   <= '0;
            miss_idx_r   <= '0;
            miss_word_r  <= '0;
            victim_r     <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_r[s] <= '0;
                ptr_r[s]   <= '0;
            end
        end else begin
            cpu_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (flush) begin
                        for (int s = 0; s < NUM_SETS; s++) begin
                            valid_r[s] <= '0;
                        end
                    end else if (cpu_req) begin
                        if (hit_s) begin
                            cpu_instr_r <= rd_data_s;
                            cpu_valid_r <= 1'b1;
                        end else begin
                            miss_tag_r  <= req_tag_s;
                            miss_idx_r  <= req_idx_s;
                            miss_word_r <= req_word_s;
                            victim_r    <= ptr_r[req_idx_s];
                            mem_addr_r  <= {cpu_addr[31:OFFSET_BITS+2], {(OFFSET_BITS + 2){1'b0}}};
                            mem_req_r   <= 1'b1;
                            stall_r     <= 1'b1;
                            state_r     <= ST_MISS_REQ;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MISS_REQ: begin
                    if (flush) begin
                        pend_flush_r <= 1'b1;
                    end else begin
                        pend_flush_r <= pend_flush_r;
                    end
                    if (mem_gnt) begin
                        mem_req_r <= 1'b0;
                        cnt_r     <= '0;
                        state_r   <= ST_FILL;
                    end else begin
                        state_r <= ST_MISS_REQ;
                    end
                end
                ST_FILL: begin
                    if (flush) begin
                        pend_flush_r <= 1'b1;
                    end else begin
                        pend_flush_r <= pend_flush_r;
                    end
                    if (mem_rvalid) begin
                        if (cnt_r == miss_word_r) begin
                            cpu_instr_r <= mem_rdata;
                        end else begin
                            cpu_instr_r <= cpu_instr_r;
                        end
                        cnt_r <= cnt_r + OFF_W'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                    if (last_s) begin
                        // A flush seen during the refill wins over the freshly filled line.
                        if (pend_flush_r || flush) begin
                            for (int s = 0; s < NUM_SETS; s++) begin
                                valid_r[s] <= '0;
                            end
                        end else begin
                            valid_r[miss_idx_r][victim_r] <= 1'b1;
                        end
                        ptr_r[miss_idx_r] <= (WAYS > 1) ? ptr_r[miss_idx_r] + WAY_W'(1) : WAY_W'(0);
                        cnt_r        <= '0;
                        pend_flush_r <= 1'b0;
                        cpu_valid_r  <= 1'b1;
                        stall_r      <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_FILL;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    stall_r   <= 1'b0;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Line data and tag storage; contents are qualified by valid_r so no reset is needed.
    always_ff @(posedge clk) begin
        if (beat_s) begin
            data_r[miss_idx_r][victim_r][cnt_r] <= mem_rdata;
        end else begin
            data_r[miss_idx_r][victim_r][cnt_r] <= data_r[miss_idx_r][victim_r][cnt_r];
        end
        if (last_s) begin
            tag_r[miss_idx_r][victim_r] <= miss_tag_r;
        end else begin
            tag_r[miss_idx_r][victim_r] <= tag_r[miss_idx_r][victim_r];
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_r;
    logic [31:0] miss_count_r;

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;

    // Accepted-request counters; only reset_n clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else if (accept_s && hit_s) begin
            hit_count_r <= hit_count_r + 32'd1;
        end else if (accept_s) begin
            miss_count_r <= miss_count_r + 32'd1;
        end else begin
            hit_count_r <= hit_count_r;
        end
    end
`endif

endmodule
